// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- multi-cycle unsigned restoring divider.
//
// Divides a 2*DATA_WIDTH-bit dividend by a DATA_WIDTH-bit divisor and produces
// one quotient bit per clock. Operands are taken on a valid/ready handshake and
// the result is held on a second valid/ready handshake until it is consumed.
// A zero divisor does not shorten the run. It returns an all-ones quotient, the
// low DATA_WIDTH bits of the dividend as remainder, and raises div_zero.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   A/B are valid
//   in_ready   block can accept A/B (IDLE only)
//   A          dividend, 2*DATA_WIDTH bits, unsigned
//   B          divisor, DATA_WIDTH bits, unsigned
//   out_valid  Q/R/div_zero are valid (DONE)
//   out_ready  consumer accepts the result
//   Q          quotient, 2*DATA_WIDTH bits
//   R          remainder, DATA_WIDTH bits
//   div_zero   B was zero for this result
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int DATA_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]     B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   Q,
  output logic [DATA_WIDTH-1:0]     R,
  output logic                      div_zero
);

  localparam int QW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(QW) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rem;        // partial remainder carried between iterations
  logic [QW-1:0]         dvd;        // dividend bits shift out the top, quotient bits shift in
  logic [DATA_WIDTH-1:0] divisor;

  logic [DATA_WIDTH:0]   rem_shift;  // one bit wider so the compare cannot overflow
  logic [DATA_WIDTH-1:0] rem_next;
  logic                  q_bit;
  logic                  last_iter;
  logic                  accept;

  assign accept = in_valid && in_ready;

  // One restoring step. With a zero divisor the compare always succeeds and
  // nothing is subtracted. The quotient is then all ones and the dividend's low
  // bits are left behind in the remainder.
  always_comb begin
    rem_shift = {rem, dvd[QW-1]};
    q_bit     = (rem_shift >= {1'b0, divisor});
    rem_next  = q_bit ? DATA_WIDTH'(rem_shift - {1'b0, divisor})
                      : rem_shift[DATA_WIDTH-1:0];
    last_iter = (count == CW'(QW - 1));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: registered state is always written with <= so every flop samples
  // pre-edge values, independent of the order the simulator runs processes in.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block keeps
  // every path assigned, so no latch is inferred for state_next.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath. Operands are captured only on acceptance, so A/B changes outside
  // IDLE are ignored. Q/R/div_zero load only on the final CALC iteration.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rem      <= '0;
      dvd      <= '0;
      divisor  <= '0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dvd     <= A;
            divisor <= B;
            rem     <= '0;
            count   <= '0;
          end
        end
        CALC: begin
          dvd   <= {dvd[QW-2:0], q_bit};
          rem   <= rem_next;
          // The counter leaves CALC at QW-1, so it never passes QW and never wraps.
          count <= count + 1'b1;
          if (last_iter) begin
            Q        <= {dvd[QW-2:0], q_bit};
            R        <= rem_next;
            div_zero <= (divisor == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
